// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: issues mul/div from X, stalls until md_ready, presents one result beat (optional timeout via MD_TIMEOUT_EN)
module multdiv_issue_ctrl #(
    parameter int MUL_LAT       = 17,
    parameter int DIV_LAT       = 33,
    parameter int TIMEOUT_SLACK = 4,
    parameter int CNT_W         = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] x_instruction,
    input  logic [31:0] x_opA,
    input  logic [31:0] x_opB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        result_valid,
    output logic        result_we,
    output logic [4:0]  result_rd,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic kind_div, exc_q, is_mul, is_div, issue, timeout;
    logic [4:0] rd;
    logic [31:0] opa_q, opb_q, data_q;
    logic [CNT_W-1:0] cnt, limit;
    // decode mul/div in X; a start is only honoured from IDLE and never during reset
    always_comb begin
        is_mul = x_instruction[31:27] == 5'b00000 && x_instruction[6:2] == 5'b00110;
        is_div = x_instruction[31:27] == 5'b00000 && x_instruction[6:2] == 5'b00111;
        issue  = state == IDLE && (is_mul || is_div) && !reset;
        limit  = kind_div ? CNT_W'(DIV_LAT + TIMEOUT_SLACK) : CNT_W'(MUL_LAT + TIMEOUT_SLACK);
    end
`ifdef MD_TIMEOUT_EN
    assign timeout = state == BUSY && cnt == limit;
`else
    assign timeout = 1'b0 && cnt == limit;
`endif
    // issue/busy/done sequencing and operand/result capture
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            kind_div <= 1'b0;
            rd       <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            data_q   <= '0;
            exc_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    kind_div <= is_div;
                    rd       <= x_instruction[26:22];
                    opa_q    <= x_opA;
                    opb_q    <= x_opB;
                    cnt      <= '0;
                    state    <= BUSY;
                end
                BUSY: begin
                    cnt <= &cnt ? cnt : cnt + 1'b1;
                    if (md_ready) begin
                        data_q <= md_result;
                        exc_q  <= md_exception;
                        state  <= DONE;
                    end else if (timeout) begin
                        exc_q <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // start pulses and stall are combinational; result beat comes from captured state in DONE
    always_comb begin
        ctrl_mult    = issue && is_mul;
        ctrl_div     = issue && is_div;
        stall        = issue || state == BUSY;
        md_opA       = state == IDLE ? (issue ? x_opA : '0) : opa_q;
        md_opB       = state == IDLE ? (issue ? x_opB : '0) : opb_q;
        result_valid = state == DONE;
        result_we    = result_valid && (exc_q || rd != 5'd0);
        result_rd    = !result_valid ? 5'd0 : exc_q ? 5'd30 : rd;
        result       = !result_valid ? 32'd0 : exc_q ? {29'd0, 2'b10, kind_div} : data_q;
    end
endmodule
